load_store_unit: RTL and testbench

//   Multi-cycle data-memory stage downstream of execute: takes ALU address + store data,

---
 rtl/load_store_unit_if.sv | 23 ++
 rtl/load_store_unit.sv | 142 ++++++++++++++
 tb/tb_load_store_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response bundle between execute and the load/store unit
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        stall;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, stall
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle RV64 load/store stage over a private doubleword array
module load_store_unit #(
    parameter int MEM_DEPTH   = 1024,
    parameter int MEM_LATENCY = 2
) (
    input  logic             clock,
    input  logic             reset,
    load_store_unit_if.slave lsu
);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int ADDR_W = IDX_W + 3;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t              state, state_next;
    logic [3:0]          counter;
    logic                acc_we;
    logic [2:0]          acc_funct3;
    logic [ADDR_W-1:0]   acc_addr;
    logic [63:0]         acc_wdata;
    logic [63:0]         resp_rdata_q;
    logic                resp_err_q;
    logic [63:0]         mem [MEM_DEPTH];

    logic                req_legal;
    logic                commit;
    logic [IDX_W-1:0]    acc_idx;
    logic [63:0]         lane;
    logic [63:0]         load_data;
    logic [7:0]          byte_en_base;
    logic [7:0]          byte_en;
    logic [63:0]         wdata_sh;

    assign lsu.req_ready  = (state == S_IDLE);
    assign lsu.stall      = (state == S_ACCESS);
    assign lsu.resp_valid = (state == S_RESP);
    assign lsu.resp_rdata = resp_rdata_q;
    assign lsu.resp_err   = resp_err_q;

    assign commit   = (state == S_ACCESS) && (counter == 4'd0);
    assign acc_idx  = acc_addr[ADDR_W-1:3];
    assign lane     = mem[acc_idx] >> {acc_addr[2:0], 3'b000};
    assign byte_en  = byte_en_base << acc_addr[2:0];
    assign wdata_sh = acc_wdata << {acc_addr[2:0], 3'b000};

    // Legality is judged on the live request so an illegal one never reaches ACCESS.
    always_comb begin
        req_legal = 1'b1;
        case (lsu.req_funct3[1:0])
            2'b01:   if (lsu.req_addr[0])        req_legal = 1'b0;
            2'b10:   if (lsu.req_addr[1:0] != 0) req_legal = 1'b0;
            2'b11:   if (lsu.req_addr[2:0] != 0) req_legal = 1'b0;
            default: ;
        endcase
        if (lsu.req_addr[63:ADDR_W] != '0)                req_legal = 1'b0;
        if (!lsu.req_we && (lsu.req_funct3 == 3'b111))  req_legal = 1'b0;
        if (lsu.req_we && lsu.req_funct3[2])            req_legal = 1'b0;
    end

    always_comb begin
        case (acc_funct3)
            3'b000:  load_data = {{56{lane[7]}},  lane[7:0]};
            3'b001:  load_data = {{48{lane[15]}}, lane[15:0]};
            3'b010:  load_data = {{32{lane[31]}}, lane[31:0]};
            3'b100:  load_data = {56'd0, lane[7:0]};
            3'b101:  load_data = {48'd0, lane[15:0]};
            3'b110:  load_data = {32'd0, lane[31:0]};
            default: load_data = lane;
        endcase
    end

    always_comb begin
        case (acc_funct3[1:0])
            2'b00:   byte_en_base = 8'h01;
            2'b01:   byte_en_base = 8'h03;
            2'b10:   byte_en_base = 8'h0F;
            default: byte_en_base = 8'hFF;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (lsu.req_valid) state_next = req_legal ? S_ACCESS : S_RESP;
            S_ACCESS: if (counter == 4'd0) state_next = S_RESP;
            S_RESP:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter      <= 4'd0;
            acc_we       <= 1'b0;
            acc_funct3   <= 3'd0;
            acc_addr     <= '0;
            acc_wdata    <= 64'd0;
            resp_rdata_q <= 64'd0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (lsu.req_valid) begin
                        acc_we     <= lsu.req_we;
                        acc_funct3 <= lsu.req_funct3;
                        acc_addr   <= lsu.req_addr[ADDR_W-1:0];
                        acc_wdata  <= lsu.req_wdata;
                        if (req_legal) begin
                            counter <= 4'(MEM_LATENCY - 1);
                        end else begin
                            resp_rdata_q <= 64'd0;
                            resp_err_q   <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    if (counter == 4'd0) begin
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= acc_we ? 64'd0 : load_data;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Array has no reset; a store is only written at its commit edge, so reset earlier drops it.
    always_ff @(posedge clock) begin
        if (commit && acc_we) begin
            for (int i = 0; i < 8; i++) begin
                if (byte_en[i]) mem[acc_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed bench driving three latency variants in lockstep
module tb_load_store_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    load_store_unit_if if_l1 ();
    load_store_unit_if if_l2 ();
    load_store_unit_if if_l3 ();

    load_store_unit #(.MEM_DEPTH(1024), .MEM_LATENCY(1)) u_l1 (.clock(clock), .reset(reset), .lsu(if_l1.slave));
    load_store_unit #(.MEM_DEPTH(1024), .MEM_LATENCY(2)) u_l2 (.clock(clock), .reset(reset), .lsu(if_l2.slave));
    load_store_unit #(.MEM_DEPTH(1024), .MEM_LATENCY(3)) u_l3 (.clock(clock), .reset(reset), .lsu(if_l3.slave));

    assign if_l1.req_valid = req_valid;  assign if_l2.req_valid = req_valid;  assign if_l3.req_valid = req_valid;
    assign if_l1.req_we = req_we;        assign if_l2.req_we = req_we;        assign if_l3.req_we = req_we;
    assign if_l1.req_funct3 = req_funct3; assign if_l2.req_funct3 = req_funct3; assign if_l3.req_funct3 = req_funct3;
    assign if_l1.req_addr = req_addr;    assign if_l2.req_addr = req_addr;    assign if_l3.req_addr = req_addr;
    assign if_l1.req_wdata = req_wdata;  assign if_l2.req_wdata = req_wdata;  assign if_l3.req_wdata = req_wdata;

    // Index i runs the DUT with MEM_LATENCY = i+1.
    logic        rv  [3];
    logic        rdy [3];
    logic        st  [3];
    logic [63:0] rd  [3];
    logic        er  [3];
    assign rv[0] = if_l1.resp_valid; assign rv[1] = if_l2.resp_valid; assign rv[2] = if_l3.resp_valid;
    assign rdy[0] = if_l1.req_ready; assign rdy[1] = if_l2.req_ready; assign rdy[2] = if_l3.req_ready;
    assign st[0] = if_l1.stall;      assign st[1] = if_l2.stall;      assign st[2] = if_l3.stall;
    assign rd[0] = if_l1.resp_rdata; assign rd[1] = if_l2.resp_rdata; assign rd[2] = if_l3.resp_rdata;
    assign er[0] = if_l1.resp_err;   assign er[1] = if_l2.resp_err;   assign er[2] = if_l3.resp_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s ready L%0d", tag, i + 1), 64'(rdy[i]), 64'd1);
            check($sformatf("%s resp_valid L%0d", tag, i + 1), 64'(rv[i]), 64'd0);
            check($sformatf("%s stall L%0d", tag, i + 1), 64'(st[i]), 64'd0);
            check($sformatf("%s rdata L%0d", tag, i + 1), rd[i], 64'd0);
            check($sformatf("%s err L%0d", tag, i + 1), 64'(er[i]), 64'd0);
        end
    endtask

    // Issues one request at a negedge, scrambles req_* after acceptance, then watches 12 cycles.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] exp_rdata, input logic exp_err);
        int lat [3], stall_cnt [3], rdy_lo [3], resp_cnt [3];
        logic [63:0] got_rdata [3];
        logic        got_err [3];
        for (int i = 0; i < 3; i++) begin
            lat[i] = 0; stall_cnt[i] = 0; rdy_lo[i] = 0; resp_cnt[i] = 0;
            got_rdata[i] = 64'hX; got_err[i] = 1'bX;
        end
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        check({tag, " ready before accept"}, 64'(rdy[1]), 64'd1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_we = ~we;
        req_funct3 = 3'b011;
        req_addr = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            for (int i = 0; i < 3; i++) begin
                if (rv[i]) begin
                    resp_cnt[i]++;
                    if (lat[i] == 0) lat[i] = k;
                    got_rdata[i] = rd[i];
                    got_err[i] = er[i];
                end
                if (st[i]) stall_cnt[i]++;
                if (!rdy[i]) rdy_lo[i]++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s latency L%0d", tag, i + 1), 64'(lat[i]), exp_err ? 64'd1 : 64'(i + 2));
            check($sformatf("%s stall cycles L%0d", tag, i + 1), 64'(stall_cnt[i]), exp_err ? 64'd0 : 64'(i + 1));
            check($sformatf("%s ready-low cycles L%0d", tag, i + 1), 64'(rdy_lo[i]), exp_err ? 64'd1 : 64'(i + 2));
            check($sformatf("%s resp pulses L%0d", tag, i + 1), 64'(resp_cnt[i]), 64'd1);
            check($sformatf("%s rdata L%0d", tag, i + 1), got_rdata[i], exp_rdata);
            check($sformatf("%s err L%0d", tag, i + 1), 64'(got_err[i]), 64'(exp_err));
        end
        check({tag, " rdata held"}, rd[1], exp_rdata);
    endtask

    initial begin
        int resp_seen;
        @(negedge clock);
        @(negedge clock);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clock);

        do_req("SD 0x10", 1'b1, 3'b011, 64'h10, 64'hFFEEDDCCBBAA9988, 64'd0, 1'b0);
        do_req("LD 0x10", 1'b0, 3'b011, 64'h10, 64'd0, 64'hFFEEDDCCBBAA9988, 1'b0);

        do_req("SB 0x13", 1'b1, 3'b000, 64'h13, 64'h1234567890ABCD80, 64'd0, 1'b0);
        do_req("LB 0x13", 1'b0, 3'b000, 64'h13, 64'd0, 64'hFFFFFFFFFFFFFF80, 1'b0);
        do_req("LBU 0x13", 1'b0, 3'b100, 64'h13, 64'd0, 64'h0000000000000080, 1'b0);
        do_req("LD lane3", 1'b0, 3'b011, 64'h10, 64'd0, 64'hFFEEDDCC80AA9988, 1'b0);
        do_req("LH 0x12", 1'b0, 3'b001, 64'h12, 64'd0, 64'hFFFFFFFFFFFF80AA, 1'b0);
        do_req("LHU 0x12", 1'b0, 3'b101, 64'h12, 64'd0, 64'h00000000000080AA, 1'b0);
        do_req("LW 0x14", 1'b0, 3'b010, 64'h14, 64'd0, 64'hFFFFFFFFFFEEDDCC, 1'b0);
        do_req("LWU 0x14", 1'b0, 3'b110, 64'h14, 64'd0, 64'h00000000FFEEDDCC, 1'b0);

        do_req("LW 0x22 misaligned", 1'b0, 3'b010, 64'h22, 64'd0, 64'd0, 1'b1);
        do_req("SD 0x20", 1'b1, 3'b011, 64'h20, 64'h0011223344556677, 64'd0, 1'b0);
        do_req("SH 0x21 misaligned", 1'b1, 3'b001, 64'h21, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1);
        do_req("LD 0x20 unchanged", 1'b0, 3'b011, 64'h20, 64'd0, 64'h0011223344556677, 1'b0);

        do_req("SD last dword", 1'b1, 3'b011, 64'h1FF8, 64'hA5A55A5A0F0FF0F0, 64'd0, 1'b0);
        do_req("LD last dword", 1'b0, 3'b011, 64'h1FF8, 64'd0, 64'hA5A55A5A0F0FF0F0, 1'b0);
        do_req("LD 0x2000 range", 1'b0, 3'b011, 64'h2000, 64'd0, 64'd0, 1'b1);
        do_req("load f3=111", 1'b0, 3'b111, 64'h10, 64'd0, 64'd0, 1'b1);
        do_req("store f3=110", 1'b1, 3'b110, 64'h10, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1);
        do_req("LD 0x10 after bad store", 1'b0, 3'b011, 64'h10, 64'd0, 64'hFFEEDDCC80AA9988, 1'b0);

        do_req("SD 0x8", 1'b1, 3'b011, 64'h8, 64'h0123456789ABCDEF, 64'd0, 1'b0);
        do_req("LD 0x8", 1'b0, 3'b011, 64'h8, 64'd0, 64'h0123456789ABCDEF, 1'b0);

        // Abort a store during ACCESS, before any variant reaches its commit edge.
        req_we = 1'b1; req_funct3 = 3'b011; req_addr = 64'h8; req_wdata = 64'hDEADBEEFCAFEF00D;
        req_valid = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        #1;
        reset = 1'b1;
        @(negedge clock);
        check_reset_values("reset mid-access");
        resp_seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) reset = 1'b0;
            @(negedge clock);
            for (int i = 0; i < 3; i++) if (rv[i]) resp_seen++;
        end
        check("no resp after abort", 64'(resp_seen), 64'd0);
        do_req("LD 0x8 old data", 1'b0, 3'b011, 64'h8, 64'd0, 64'h0123456789ABCDEF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
